// File: rtl/ascal_window_ctrl_if.sv
// ascal_window_ctrl_if
// Bundles the signals between hps_io / HDMI timing and the window editor.
//   ps2_key [10:0] : [10] toggle per event, [9] pressed, [8] E0-extended, [7:0] scancode
//   hdisp   [11:0] : HDMI active width, 0 = unknown
//   vdisp   [11:0] : HDMI active height, 0 = unknown
//   hmin/hmax/vmin/vmax [11:0] : current window edges (inclusive)
//   sel     [1:0]  : selected edge 0=LEFT 1=RIGHT 2=TOP 3=BOTTOM
//   upd            : one-cycle pulse when any window edge changes
// master drives the key/display inputs, slave is the window controller.
interface ascal_window_ctrl_if;
  logic [10:0] ps2_key;
  logic [11:0] hdisp;
  logic [11:0] vdisp;
  logic [11:0] hmin;
  logic [11:0] hmax;
  logic [11:0] vmin;
  logic [11:0] vmax;
  logic [1:0]  sel;
  logic        upd;

  modport master (
    output ps2_key, hdisp, vdisp,
    input  hmin, hmax, vmin, vmax, sel, upd
  );

  modport slave (
    input  ps2_key, hdisp, vdisp,
    output hmin, hmax, vmin, vmax, sel, upd
  );
endinterface

// File: rtl/ascal_window_ctrl.sv
// ascal_window_ctrl
// Keyboard-driven output-window editor for the AscalTest scaler.
// Tab cycles the selected edge, arrows move it (Shift = fast step), R resets the
// window to full screen; a held arrow auto-repeats after an initial delay.
// The window follows the HDMI display size whenever a new non-zero size appears.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : ascal_window_ctrl_if.slave (ps2_key/hdisp/vdisp in, window/sel/upd out)
module ascal_window_ctrl #(
  parameter int DEF_W   = 640,
  parameter int DEF_H   = 480,
  parameter int STEP    = 1,
  parameter int FSTEP   = 8,
  parameter int MINW    = 16,
  parameter int REP_DLY = 24,
  parameter int REP_PER = 8
) (
  input  logic               clk,
  input  logic               reset,
  ascal_window_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DLY  = 2'd1;
  localparam logic [1:0] ST_REP  = 2'd2;

  localparam logic [1:0] K_LEFT  = 2'd0;
  localparam logic [1:0] K_RIGHT = 2'd1;
  localparam logic [1:0] K_UP    = 2'd2;
  localparam logic [1:0] K_DOWN  = 2'd3;

  localparam int CNT_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] DLY_LAST = CW'(REP_DLY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PER - 1);
  localparam logic [11:0]   D_SLOW   = 12'(STEP);
  localparam logic [11:0]   D_FAST   = 12'(FSTEP);
  localparam logic [11:0]   GAP      = 12'(MINW);
  localparam logic [11:0]   W_RST    = 12'(DEF_W);
  localparam logic [11:0]   H_RST    = 12'(DEF_H);

  typedef struct packed {
    logic [11:0] hmin;
    logic [11:0] hmax;
    logic [11:0] vmin;
    logic [11:0] vmax;
  } win_t;

  // Increase v by d, capped at hi; a value already at/above hi is left alone.
  function automatic logic [11:0] sat_add(input logic [11:0] v,
                                          input logic [11:0] hi,
                                          input logic [11:0] d);
    logic [12:0] s;
    s = {1'b0, v} + {1'b0, d};
    if (v >= hi)
      sat_add = v;
    else if (s >= {1'b0, hi})
      sat_add = hi;
    else
      sat_add = s[11:0];
  endfunction

  // Decrease v by d, floored at lo; the difference is taken only when v > lo,
  // so nothing can wrap below zero.
  function automatic logic [11:0] sat_sub(input logic [11:0] v,
                                          input logic [11:0] lo,
                                          input logic [11:0] d);
    if (v <= lo)
      sat_sub = v;
    else if ((v - lo) <= d)
      sat_sub = lo;
    else
      sat_sub = v - d;
  endfunction

  function automatic win_t full_win(input logic [11:0] wl, input logic [11:0] hl);
    win_t r;
    r.hmin = 12'd0;
    r.hmax = wl - 12'd1;
    r.vmin = 12'd0;
    r.vmax = hl - 12'd1;
    return r;
  endfunction

  // One arrow step on the selected edge; horizontal keys only touch
  // horizontal edges and vertical keys only vertical edges.
  function automatic win_t apply_move(input win_t w, input logic [1:0] dir,
                                      input logic [1:0] s, input logic fast,
                                      input logic [11:0] wl, input logic [11:0] hl);
    win_t r;
    logic [11:0] d;
    r = w;
    d = fast ? D_FAST : D_SLOW;
    case (dir)
      K_LEFT: begin
        if (s == 2'd0)      r.hmin = sat_sub(w.hmin, 12'd0, d);
        else if (s == 2'd1) r.hmax = sat_sub(w.hmax, w.hmin + GAP, d);
      end
      K_RIGHT: begin
        if (s == 2'd0)      r.hmin = sat_add(w.hmin, w.hmax - GAP, d);
        else if (s == 2'd1) r.hmax = sat_add(w.hmax, wl - 12'd1, d);
      end
      K_UP: begin
        if (s == 2'd2)      r.vmin = sat_sub(w.vmin, 12'd0, d);
        else if (s == 2'd3) r.vmax = sat_sub(w.vmax, w.vmin + GAP, d);
      end
      K_DOWN: begin
        if (s == 2'd2)      r.vmin = sat_add(w.vmin, w.vmax - GAP, d);
        else if (s == 2'd3) r.vmax = sat_add(w.vmax, hl - 12'd1, d);
      end
    endcase
    return r;
  endfunction

  logic          tog_p1;
  win_t          win_p1;
  logic [1:0]    sel_p1;
  logic          upd_p1;
  logic          shift_p1;
  logic [11:0]   w_p1;
  logic [11:0]   h_p1;
  logic [1:0]    st_p1;
  logic [CW-1:0] cnt_p1;
  logic [1:0]    key_p1;

  logic          evt_p0;
  logic          pressed_p0;
  logic          ext_p0;
  logic [7:0]    code_p0;
  logic          arrow_p0;
  logic [1:0]    dir_p0;
  logic          disp_chg_p0;
  logic          tick_p0;
  logic          do_tick_p0;
  logic          force_upd_p0;

  win_t          win_n;
  logic [1:0]    sel_n;
  logic          shift_n;
  logic [11:0]   w_n;
  logic [11:0]   h_n;
  logic [1:0]    st_n;
  logic [CW-1:0] cnt_n;
  logic [1:0]    key_n;

  // ---- stage 0: event decode and next-state selection ----
  assign evt_p0      = bus.ps2_key[10] != tog_p1;
  assign pressed_p0  = bus.ps2_key[9];
  assign ext_p0      = bus.ps2_key[8];
  assign code_p0     = bus.ps2_key[7:0];
  assign disp_chg_p0 = ((bus.hdisp != 12'd0) && (bus.hdisp != w_p1)) ||
                       ((bus.vdisp != 12'd0) && (bus.vdisp != h_p1));
  assign tick_p0     = ((st_p1 == ST_DLY) && (cnt_p1 == DLY_LAST)) ||
                       ((st_p1 == ST_REP) && (cnt_p1 == PER_LAST));

  always_comb begin
    arrow_p0 = 1'b0;
    dir_p0   = K_LEFT;
    if (ext_p0) begin
      case (code_p0)
        8'h6B:   begin arrow_p0 = 1'b1; dir_p0 = K_LEFT;  end
        8'h74:   begin arrow_p0 = 1'b1; dir_p0 = K_RIGHT; end
        8'h75:   begin arrow_p0 = 1'b1; dir_p0 = K_UP;    end
        8'h72:   begin arrow_p0 = 1'b1; dir_p0 = K_DOWN;  end
        default: begin arrow_p0 = 1'b0; dir_p0 = K_LEFT;  end
      endcase
    end
  end

  always_comb begin
    win_n        = win_p1;
    sel_n        = sel_p1;
    shift_n      = shift_p1;
    w_n          = w_p1;
    h_n          = h_p1;
    st_n         = st_p1;
    cnt_n        = cnt_p1;
    key_n        = key_p1;
    do_tick_p0   = 1'b0;
    force_upd_p0 = 1'b0;

    if (disp_chg_p0) begin
      // A new display size overrides any key activity this cycle.
      if (bus.hdisp != 12'd0) w_n = bus.hdisp;
      if (bus.vdisp != 12'd0) h_n = bus.vdisp;
      win_n        = full_win(w_n, h_n);
      force_upd_p0 = 1'b1;
      st_n         = ST_IDLE;
      cnt_n        = '0;
    end else begin
      if (st_p1 != ST_IDLE) begin
        if (tick_p0) begin
          do_tick_p0 = 1'b1;
          cnt_n      = '0;
          st_n       = ST_REP;
        end else begin
          cnt_n = cnt_p1 + CW'(1);
        end
      end

      if (evt_p0) begin
        if (!ext_p0 && ((code_p0 == 8'h12) || (code_p0 == 8'h59))) begin
          shift_n = pressed_p0;
        end else if (pressed_p0 && (code_p0 == 8'h0D)) begin
          sel_n = sel_p1 + 2'd1;
        end else if (pressed_p0 && (code_p0 == 8'h2D)) begin
          win_n      = full_win(w_p1, h_p1);
          do_tick_p0 = 1'b0;
        end else if (arrow_p0) begin
          if (pressed_p0 && ((st_p1 == ST_IDLE) || (dir_p0 != key_p1))) begin
            // New arrow: immediate step, then re-arm the initial delay.
            win_n      = apply_move(win_p1, dir_p0, sel_p1, shift_p1, w_p1, h_p1);
            key_n      = dir_p0;
            cnt_n      = '0;
            st_n       = ST_DLY;
            do_tick_p0 = 1'b0;
          end else if (!pressed_p0 && (st_p1 != ST_IDLE) && (dir_p0 == key_p1)) begin
            st_n       = ST_IDLE;
            cnt_n      = '0;
            do_tick_p0 = 1'b0;
          end
        end
      end

      // A repeat uses the edge/shift in force before this cycle's event.
      if (do_tick_p0)
        win_n = apply_move(win_p1, key_p1, sel_p1, shift_p1, w_p1, h_p1);
    end
  end

  // ---- stage 1: registered window, selection and repeat state ----
  always_ff @(posedge clk) begin
    tog_p1 <= bus.ps2_key[10];
    if (reset) begin
      win_p1   <= full_win(W_RST, H_RST);
      sel_p1   <= 2'd0;
      upd_p1   <= 1'b0;
      shift_p1 <= 1'b0;
      w_p1     <= W_RST;
      h_p1     <= H_RST;
      st_p1    <= ST_IDLE;
      cnt_p1   <= '0;
      key_p1   <= K_LEFT;
    end else begin
      win_p1   <= win_n;
      sel_p1   <= sel_n;
      upd_p1   <= force_upd_p0 || (win_n != win_p1);
      shift_p1 <= shift_n;
      w_p1     <= w_n;
      h_p1     <= h_n;
      st_p1    <= st_n;
      cnt_p1   <= cnt_n;
      key_p1   <= key_n;
    end
  end

  assign bus.hmin = win_p1.hmin;
  assign bus.hmax = win_p1.hmax;
  assign bus.vmin = win_p1.vmin;
  assign bus.vmax = win_p1.vmax;
  assign bus.sel  = sel_p1;
  assign bus.upd  = upd_p1;

endmodule
